sfpp_reconfig_st_channel_arbiter: RTL and testbench
===================================================

Name: sfpp_reconfig_st_channel_arbiter

Overview:
- Packet-aware round-robin arbiter. Merges NUM_CH byte-wide Avalon-ST packet sources into one channelized stream.
- Its output feeds the reconfig master's bytes-to-packets channel adapter. out_channel carries the index of the granted source.
- A grant is held from SOP to EOP, so packets are never interleaved.
- The output has one registered stage, which decouples out_ready timing from the source-side handshake.

Parameters:
- NUM_CH, 4, number of requesting sources (2..16); must be <= 2**CH_W.
- DATA_W, 8, data width per beat.
- CH_W, 8, out_channel width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ch_enable  in  NUM_CH  per-source arbitration enable.
- in_valid  in  NUM_CH  source valid.
- in_ready  out  NUM_CH  source ready.
- in_data  in  NUM_CH*DATA_W  source data; source i occupies [i*DATA_W +: DATA_W].
- in_startofpacket  in  NUM_CH  source SOP.
- in_endofpacket  in  NUM_CH  source EOP.
- out_ready  in  1  sink ready.
- out_valid  out  1  sink valid (registered).
- out_data  out  DATA_W  sink data (registered).
- out_channel  out  CH_W  granted index, zero-extended (registered).
- out_startofpacket  out  1  registered.
- out_endofpacket  out  1  registered.
- busy  out  1  high while in state LOCKED.
- grant_idx  out  4  current or last grant index.
- err_orphan  out  1  one-cycle pulse on each discarded orphan beat.
- pkt_count  out  16  count of packets delivered, saturating.

Behaviour:
- Reset (synchronous, clk edge):
  - state=IDLE; rr_ptr=NUM_CH-1, so source 0 has top priority.
  - out_valid, out_startofpacket, out_endofpacket, err_orphan = 0.
  - out_data, out_channel, grant_idx, pkt_count = 0.
  - in_ready = 0 while reset is asserted.
- Output register:
  - can_acc = !out_valid || out_ready.
  - On a transfer, the register loads the source beat and sets out_valid=1.
  - If out_valid && out_ready with no new load, out_valid clears.
  - While out_valid && !out_ready, all out_* hold stable.
- State IDLE:
  - A source is eligible when in_valid[i] & in_startofpacket[i] & ch_enable[i].
  - Search order is rr_ptr+1, rr_ptr+2, ... modulo NUM_CH. The first eligible source wins: grant_idx <= i, next state LOCKED.
  - No beat transfers in the IDLE cycle, so there is a one-cycle bubble per packet.
  - Orphan beats: for every source with in_valid=1, in_startofpacket=0 and ch_enable=1, in_ready=1. The beat is discarded and err_orphan pulses. Multiple orphans in the same cycle produce a single pulse.
  - All other in_ready bits are 0.
- State LOCKED (grant g):
  - in_ready[g] = can_acc; all other in_ready bits = 0.
  - Transfer when in_valid[g] && can_acc; out_channel <= g.
  - If the transferred beat has EOP: next state IDLE, rr_ptr <= g.
  - SOP seen again mid-packet: forwarded unchanged, no error.
  - ch_enable[g] deasserting mid-packet does not abort; the packet completes.
  - A single-beat packet (SOP and EOP together) is LOCKED for one transfer, then returns to IDLE.
- pkt_count increments on out_valid && out_ready && out_endofpacket and saturates at 16'hFFFF.
- busy = (state==LOCKED).
- Latency: the SOP beat appears on out_* 2 cycles after it is presented with out_ready=1 (IDLE cycle, then registered load). Each following beat takes 1 cycle. Sustained throughput is 1 beat/clk within a packet.
- Reset asserted mid-packet: the packet is abandoned. No EOP is emitted and the downstream framer resynchronises on the next SOP. This behaviour is intentional.
- A source index i >= NUM_CH never exists; out_channel upper bits are always 0.

Test Plan:
- Single source: reset, then source 0 sends a 3-byte packet 0xA1,0xA2,0xA3 with out_ready=1.
  - Output beats appear at cycles 2,3,4 with out_channel=0, SOP on 0xA1 and EOP on 0xA3.
  - pkt_count=1; busy falls after the EOP transfer.
- Round-robin: sources 0,1,2 each hold a 2-beat packet pending.
  - Output order is channels 0,1,2, then 0 again if 0 re-requests.
  - Exactly one idle cycle separates each packet and no beats interleave.
- Backpressure: source 1 sends 4 beats while out_ready toggles 1,0,0,1,...
  - out_data/out_channel stay stable while out_ready=0.
  - in_ready[1]=0 while the register is full.
  - No beat is lost or duplicated.
- Orphan: source 3 presents 0x55 with no SOP in IDLE.
  - in_ready[3]=1, err_orphan pulses once, nothing appears on out_*, pkt_count unchanged.
- Mask and mid-packet disable: ch_enable=4'b1110 with source 0 requesting gives no grant to 0.
  - Clearing ch_enable[2] after source 2's SOP still delivers its full packet with EOP.
- Saturation/reset: preload pkt_count to 16'hFFFE and send 3 packets; pkt_count holds 16'hFFFF.
  - Assert reset mid-packet: next cycle out_valid=0, busy=0, pkt_count=0.

Source files
------------

// File: rtl/sfpp_reconfig_st_channel_arbiter_if.sv
// Avalon-ST bundle between NUM_CH packet sources, the channel arbiter and its sink.
// The arbiter takes the master modport; the sources/sink environment takes slave.
interface sfpp_reconfig_st_channel_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int CH_W   = 8
);
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_startofpacket;
    logic [NUM_CH-1:0]        in_endofpacket;
    logic                     out_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_channel;
    logic                     out_startofpacket;
    logic                     out_endofpacket;

    modport master (
        input  in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        output in_ready, out_valid, out_data, out_channel, out_startofpacket, out_endofpacket
    );

    modport slave (
        output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        input  in_ready, out_valid, out_data, out_channel, out_startofpacket, out_endofpacket
    );
endinterface

// File: rtl/sfpp_reconfig_st_channel_arbiter.sv
// Packet-aware round-robin arbiter: merges NUM_CH byte sources into one channelized
// stream, holding each grant from SOP to EOP behind a single registered output stage.
module sfpp_reconfig_st_channel_arbiter #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int CH_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_enable,
    sfpp_reconfig_st_channel_arbiter_if.master st,
    output logic              busy,
    output logic [3:0]        grant_idx,
    output logic              err_orphan,
    output logic [15:0]       pkt_count
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [3:0]        rr_ptr_q, rr_ptr_d;
    logic [3:0]        grant_q, grant_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_channel_q, out_channel_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;
    logic              err_orphan_q, err_orphan_d;
    logic [15:0]       pkt_count_q, pkt_count_d;

    logic              can_acc, xfer, found;
    logic              g_valid, g_sop, g_eop;
    logic [DATA_W-1:0] g_data;
    logic [NUM_CH-1:0] eligible, orphan, in_ready_c;

    assign can_acc  = !out_valid_q || st.out_ready;
    assign eligible = st.in_valid & st.in_startofpacket & ch_enable;
    assign orphan   = st.in_valid & ~st.in_startofpacket & ch_enable;

    always_comb begin
        g_valid = 1'b0;
        g_sop   = 1'b0;
        g_eop   = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q == 4'(i)) begin
                g_valid = st.in_valid[i];
                g_sop   = st.in_startofpacket[i];
                g_eop   = st.in_endofpacket[i];
                g_data  = st.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        in_ready_c   = '0;
        xfer         = 1'b0;
        found        = 1'b0;
        err_orphan_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Search starts just after the last packet's owner, wrapping modulo NUM_CH.
                for (int k = 1; k <= NUM_CH; k++) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (!found && eligible[i] && (i == (int'(rr_ptr_q) + k) % NUM_CH)) begin
                            found   = 1'b1;
                            grant_d = 4'(i);
                        end
                    end
                end
                if (found) state_d = LOCKED;
                in_ready_c   = orphan;
                err_orphan_d = |orphan;
            end
            LOCKED: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (grant_q == 4'(i)) in_ready_c[i] = can_acc;
                end
                xfer = g_valid && can_acc;
                if (xfer && g_eop) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        pkt_count_d   = pkt_count_q;
        if (xfer) begin
            out_valid_d   = 1'b1;
            out_data_d    = g_data;
            out_channel_d = CH_W'(grant_q);
            out_sop_d     = g_sop;
            out_eop_d     = g_eop;
        end else if (out_valid_q && st.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (out_valid_q && st.out_ready && out_eop_q && (pkt_count_q != 16'hFFFF))
            pkt_count_d = pkt_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= 4'(NUM_CH - 1);
            grant_q       <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            err_orphan_q  <= 1'b0;
            pkt_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            err_orphan_q  <= err_orphan_d;
            pkt_count_q   <= pkt_count_d;
        end
    end

    assign st.in_ready          = reset ? '0 : in_ready_c;
    assign st.out_valid         = out_valid_q;
    assign st.out_data          = out_data_q;
    assign st.out_channel       = out_channel_q;
    assign st.out_startofpacket = out_sop_q;
    assign st.out_endofpacket   = out_eop_q;
    assign busy                 = (state_q == LOCKED);
    assign grant_idx            = grant_q;
    assign err_orphan           = err_orphan_q;
    assign pkt_count            = pkt_count_q;
endmodule

// File: tb/tb_sfpp_reconfig_st_channel_arbiter.sv
// Self-checking bench: per-source beat queues drive the arbiter; delivered beats
// are compared with a packet-level round-robin / per-channel ordering model.
module tb_sfpp_reconfig_st_channel_arbiter;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int CH_W   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] ch_enable;
    logic              busy;
    logic [3:0]        grant_idx;
    logic              err_orphan;
    logic [15:0]       pkt_count;

    sfpp_reconfig_st_channel_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) st();

    sfpp_reconfig_st_channel_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset), .ch_enable(ch_enable), .st(st),
        .busy(busy), .grant_idx(grant_idx), .err_orphan(err_orphan), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] d; bit sop; bit eop;} beat_t;
    typedef struct {
        bit ov; logic [7:0] od; logic [7:0] och; bit osop; bit oeop; bit ordy;
        logic [3:0] ir; logic [3:0] fire; bit bsy; bit err; logic [3:0] gnt; logic [15:0] pkt;
    } rec_t;
    typedef struct {int ch; logic [7:0] d; bit sop; bit eop; int cyc;} del_t;

    beat_t srcq[NUM_CH][$];
    rec_t  log_q[$];
    del_t  del_q[$];
    int    vecs, errs;

    // One clock: present queue heads, sample just before the edge, pop accepted beats.
    task automatic tick();
        rec_t r;
        for (int i = 0; i < NUM_CH; i++) begin
            if (srcq[i].size() > 0) begin
                st.in_valid[i] = 1'b1;
                st.in_data[i*DATA_W +: DATA_W] = srcq[i][0].d;
                st.in_startofpacket[i] = srcq[i][0].sop;
                st.in_endofpacket[i] = srcq[i][0].eop;
            end else begin
                st.in_valid[i] = 1'b0;
                st.in_data[i*DATA_W +: DATA_W] = '0;
                st.in_startofpacket[i] = 1'b0;
                st.in_endofpacket[i] = 1'b0;
            end
        end
        #1;
        r.ov = st.out_valid; r.od = st.out_data; r.och = st.out_channel;
        r.osop = st.out_startofpacket; r.oeop = st.out_endofpacket; r.ordy = st.out_ready;
        r.ir = st.in_ready; r.fire = st.in_valid & st.in_ready;
        r.bsy = busy; r.err = err_orphan; r.gnt = grant_idx; r.pkt = pkt_count;
        log_q.push_back(r);
        @(posedge clk);
        for (int i = 0; i < NUM_CH; i++) if (r.fire[i]) void'(srcq[i].pop_front());
        @(negedge clk);
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < NUM_CH; i++) srcq[i].delete();
    endtask

    task automatic collect();
        del_t d;
        del_q.delete();
        for (int c = 0; c < log_q.size(); c++) begin
            if (log_q[c].ov && log_q[c].ordy) begin
                d.ch = int'(log_q[c].och); d.d = log_q[c].od;
                d.sop = log_q[c].osop; d.eop = log_q[c].oeop; d.cyc = c;
                del_q.push_back(d);
            end
        end
    endtask

    task automatic push_pkt(input int ch, input logic [7:0] base, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d = base + 8'(k); b.sop = (k == 0); b.eop = (k == len - 1);
            srcq[ch].push_back(b);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; clear_srcs(); ch_enable = '1; st.out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0; log_q.delete();
    endtask

    task automatic test_reset();
        beat_t b;
        reset = 1'b1; ch_enable = '1; st.out_ready = 1'b1; log_q.delete();
        b.d = 8'h11; b.sop = 1; b.eop = 1; srcq[0].push_back(b);
        b.d = 8'h22; b.sop = 0; b.eop = 0; srcq[1].push_back(b);
        tick(); tick();
        vecs++; if (log_q[1].ir !== 4'b0000) begin errs++; $display("FAIL reset_in_ready: got %b expected 0000", log_q[1].ir); end
        vecs++; if (log_q[1].ov !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b expected 0", log_q[1].ov); end
        vecs++; if (log_q[1].bsy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", log_q[1].bsy); end
        vecs++; if (log_q[1].err !== 1'b0) begin errs++; $display("FAIL reset_err: got %b expected 0", log_q[1].err); end
        vecs++; if (log_q[1].pkt !== 16'h0) begin errs++; $display("FAIL reset_pkt: got %h expected 0", log_q[1].pkt); end
        vecs++; if (log_q[1].od !== 8'h0 || log_q[1].och !== 8'h0) begin errs++; $display("FAIL reset_out_fields: got %h/%h expected 00/00", log_q[1].od, log_q[1].och); end
        vecs++; if (log_q[1].gnt !== 4'h0) begin errs++; $display("FAIL reset_grant: got %h expected 0", log_q[1].gnt); end
        vecs++; if (log_q[1].osop !== 1'b0 || log_q[1].oeop !== 1'b0) begin errs++; $display("FAIL reset_sop_eop: got %b%b expected 00", log_q[1].osop, log_q[1].oeop); end
        clear_srcs(); reset = 1'b0; log_q.delete();
    endtask

    task automatic test_single_packet();
        logic [7:0] exp_d [3];
        bit eo, eb;
        exp_d = '{8'hA1, 8'hA2, 8'hA3};
        do_reset();
        push_pkt(0, 8'hA1, 3);
        for (int c = 0; c < 8; c++) tick();
        for (int c = 0; c < 8; c++) begin
            eo = (c >= 2 && c <= 4);
            eb = (c >= 1 && c <= 3);
            vecs++; if (log_q[c].ov !== eo) begin errs++; $display("FAIL single_valid c%0d: got %b expected %b", c, log_q[c].ov, eo); end
            vecs++; if (log_q[c].bsy !== eb) begin errs++; $display("FAIL single_busy c%0d: got %b expected %b", c, log_q[c].bsy, eb); end
            vecs++; if (log_q[c].pkt !== ((c >= 5) ? 16'd1 : 16'd0)) begin errs++; $display("FAIL single_pkt c%0d: got %0d expected %0d", c, log_q[c].pkt, (c >= 5) ? 1 : 0); end
            if (eo) begin
                vecs++;
                if (log_q[c].od !== exp_d[c-2] || log_q[c].och !== 8'd0 || log_q[c].osop !== (c == 2) || log_q[c].oeop !== (c == 4)) begin
                    errs++; $display("FAIL single_beat c%0d: got d=%h ch=%0d s=%b e=%b expected d=%h ch=0 s=%b e=%b",
                                     c, log_q[c].od, log_q[c].och, log_q[c].osop, log_q[c].oeop, exp_d[c-2], c == 2, c == 4);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int left [NUM_CH];
        int used [NUM_CH];
        int order[$];
        del_t exp_b[$];
        del_t e;
        int last, pick, n;
        do_reset();
        left = '{2, 1, 1, 0};
        used = '{0, 0, 0, 0};
        for (int c = 0; c < NUM_CH; c++)
            for (int p = 0; p < left[c]; p++) push_pkt(c, 8'(16*c + 8*p), 2);
        last = NUM_CH - 1;
        for (int guard = 0; guard < 16; guard++) begin
            pick = -1;
            for (int k = 1; k <= NUM_CH; k++)
                if (pick < 0 && left[(last + k) % NUM_CH] > 0) pick = (last + k) % NUM_CH;
            if (pick >= 0) begin
                order.push_back(pick); left[pick]--; last = pick;
            end
        end
        foreach (order[j]) begin
            n = used[order[j]]++;
            for (int b = 0; b < 2; b++) begin
                e.ch = order[j]; e.d = 8'(16*order[j] + 8*n + b); e.sop = (b == 0); e.eop = (b == 1); e.cyc = 0;
                exp_b.push_back(e);
            end
        end
        for (int c = 0; c < 20; c++) tick();
        collect();
        vecs++; if (del_q.size() != exp_b.size()) begin errs++; $display("FAIL rr_count: got %0d expected %0d", del_q.size(), exp_b.size()); end
        for (int j = 0; j < del_q.size() && j < exp_b.size(); j++) begin
            vecs++;
            if (del_q[j].ch != exp_b[j].ch || del_q[j].d !== exp_b[j].d || del_q[j].sop != exp_b[j].sop || del_q[j].eop != exp_b[j].eop) begin
                errs++; $display("FAIL rr_beat %0d: got ch=%0d d=%h s=%b e=%b expected ch=%0d d=%h s=%b e=%b", j,
                                 del_q[j].ch, del_q[j].d, del_q[j].sop, del_q[j].eop, exp_b[j].ch, exp_b[j].d, exp_b[j].sop, exp_b[j].eop);
            end
            if (del_q[j].eop && j + 1 < del_q.size()) begin
                vecs++;
                if (del_q[j+1].cyc - del_q[j].cyc != 2) begin
                    errs++; $display("FAIL rr_gap %0d: got %0d cycles expected 2", j, del_q[j+1].cyc - del_q[j].cyc);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        beat_t sent[$];
        int bad_hold, bad_rdy;
        do_reset();
        push_pkt(1, 8'($urandom_range(0, 200)), 4);
        sent = srcq[1];
        bad_hold = 0; bad_rdy = 0;
        for (int c = 0; c < 30; c++) begin
            st.out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            tick();
        end
        for (int c = 0; c + 1 < log_q.size(); c++) begin
            if (log_q[c].ov && !log_q[c].ordy) begin
                vecs++;
                if (!log_q[c+1].ov || log_q[c+1].od !== log_q[c].od || log_q[c+1].och !== log_q[c].och ||
                    log_q[c+1].osop !== log_q[c].osop || log_q[c+1].oeop !== log_q[c].oeop) begin
                    errs++; bad_hold++;
                    $display("FAIL bp_hold c%0d: got d=%h ch=%0d expected d=%h ch=%0d", c + 1, log_q[c+1].od, log_q[c+1].och, log_q[c].od, log_q[c].och);
                end
                vecs++;
                if (log_q[c].ir[1] !== 1'b0) begin errs++; bad_rdy++; $display("FAIL bp_in_ready c%0d: got 1 expected 0", c); end
            end
        end
        collect();
        vecs++; if (del_q.size() != 4) begin errs++; $display("FAIL bp_count: got %0d expected 4", del_q.size()); end
        for (int j = 0; j < del_q.size() && j < 4; j++) begin
            vecs++;
            if (del_q[j].ch != 1 || del_q[j].d !== sent[j].d || del_q[j].sop != sent[j].sop || del_q[j].eop != sent[j].eop) begin
                errs++; $display("FAIL bp_beat %0d: got ch=%0d d=%h expected ch=1 d=%h", j, del_q[j].ch, del_q[j].d, sent[j].d);
            end
        end
        st.out_ready = 1'b1;
    endtask

    task automatic test_orphan();
        beat_t b;
        int n_err, n_ov;
        do_reset();
        b.d = 8'h55; b.sop = 0; b.eop = 0; srcq[3].push_back(b);
        for (int c = 0; c < 6; c++) tick();
        n_err = 0; n_ov = 0;
        foreach (log_q[c]) begin n_err += int'(log_q[c].err); n_ov += int'(log_q[c].ov); end
        vecs++; if (log_q[0].ir !== 4'b1000) begin errs++; $display("FAIL orphan_in_ready: got %b expected 1000", log_q[0].ir); end
        vecs++; if (n_err != 1 || log_q[1].err !== 1'b1) begin errs++; $display("FAIL orphan_pulse: got %0d pulses expected 1 at cycle 1", n_err); end
        vecs++; if (n_ov != 0) begin errs++; $display("FAIL orphan_no_output: got %0d valid cycles expected 0", n_ov); end
        vecs++; if (log_q[5].pkt !== 16'd0) begin errs++; $display("FAIL orphan_pkt: got %0d expected 0", log_q[5].pkt); end
        vecs++; if (srcq[3].size() != 0) begin errs++; $display("FAIL orphan_consumed: got %0d left expected 0", srcq[3].size()); end
        log_q.delete();
        b.d = 8'h66; b.sop = 0; b.eop = 1; srcq[2].push_back(b);
        b.d = 8'h77; b.sop = 0; b.eop = 0; srcq[3].push_back(b);
        for (int c = 0; c < 6; c++) tick();
        n_err = 0;
        foreach (log_q[c]) n_err += int'(log_q[c].err);
        vecs++; if (log_q[0].ir !== 4'b1100) begin errs++; $display("FAIL orphan_multi_ready: got %b expected 1100", log_q[0].ir); end
        vecs++; if (n_err != 1) begin errs++; $display("FAIL orphan_multi_pulse: got %0d pulses expected 1", n_err); end
    endtask

    task automatic test_mask_disable();
        bit cleared;
        int bad0, ch0_out;
        do_reset();
        ch_enable = 4'b1110;
        push_pkt(0, 8'h30, 2);
        push_pkt(2, 8'hC0, 4);
        cleared = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (!cleared && log_q[log_q.size()-1].fire[2]) begin ch_enable = 4'b1010; cleared = 1; end
        end
        bad0 = 0;
        foreach (log_q[c]) if (log_q[c].ir[0]) bad0++;
        collect();
        ch0_out = 0;
        foreach (del_q[j]) if (del_q[j].ch == 0) ch0_out++;
        vecs++; if (bad0 != 0 || ch0_out != 0) begin errs++; $display("FAIL mask_src0: got ready=%0d beats=%0d expected 0/0", bad0, ch0_out); end
        vecs++; if (srcq[0].size() != 2) begin errs++; $display("FAIL mask_src0_pending: got %0d expected 2", srcq[0].size()); end
        vecs++; if (del_q.size() != 4) begin errs++; $display("FAIL mask_count: got %0d expected 4", del_q.size()); end
        for (int j = 0; j < del_q.size() && j < 4; j++) begin
            vecs++;
            if (del_q[j].ch != 2 || del_q[j].d !== 8'(8'hC0 + j) || del_q[j].sop != (j == 0) || del_q[j].eop != (j == 3)) begin
                errs++; $display("FAIL mask_beat %0d: got ch=%0d d=%h e=%b expected ch=2 d=%h e=%b", j, del_q[j].ch, del_q[j].d, del_q[j].eop, 8'(8'hC0 + j), j == 3);
            end
        end
        ch_enable = '1;
    endtask

    task automatic test_saturation_reset();
        logic [15:0] model;
        do_reset();
        force dut.pkt_count_q = 16'hFFFE;
        tick();
        release dut.pkt_count_q;
        log_q.delete();
        tick();
        vecs++; if (log_q[0].pkt !== 16'hFFFE) begin errs++; $display("FAIL sat_preload: got %h expected fffe", log_q[0].pkt); end
        log_q.delete();
        for (int c = 0; c < 3; c++) push_pkt(c, 8'(8'h40 + 16*c), 2);
        for (int c = 0; c < 20; c++) tick();
        model = 16'hFFFE;
        foreach (log_q[c]) begin
            vecs++;
            if (log_q[c].pkt !== model) begin errs++; $display("FAIL sat_count c%0d: got %h expected %h", c, log_q[c].pkt, model); end
            if (log_q[c].ov && log_q[c].ordy && log_q[c].oeop && model != 16'hFFFF) model = model + 16'd1;
        end
        vecs++; if (log_q[log_q.size()-1].pkt !== 16'hFFFF) begin errs++; $display("FAIL sat_final: got %h expected ffff", log_q[log_q.size()-1].pkt); end
        log_q.delete();
        push_pkt(3, 8'h90, 4);
        tick(); tick(); tick();
        vecs++; if (!(log_q[2].ov && log_q[2].bsy)) begin errs++; $display("FAIL rst_mid_pre: got valid=%b busy=%b expected 1/1", log_q[2].ov, log_q[2].bsy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_srcs();
        tick();
        vecs++; if (log_q[4].ov !== 1'b0) begin errs++; $display("FAIL rst_mid_valid: got %b expected 0", log_q[4].ov); end
        vecs++; if (log_q[4].bsy !== 1'b0) begin errs++; $display("FAIL rst_mid_busy: got %b expected 0", log_q[4].bsy); end
        vecs++; if (log_q[4].pkt !== 16'h0) begin errs++; $display("FAIL rst_mid_pkt: got %h expected 0", log_q[4].pkt); end
    endtask

    task automatic test_random();
        beat_t expq[NUM_CH][$];
        int total_pkts, cur_ch, done_at, nleft;
        bit in_pkt;
        do_reset();
        total_pkts = 0;
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int p = 0; p < 5; p++) begin
                push_pkt(ch, 8'($urandom_range(0, 255)), int'($urandom_range(1, 5)));
                total_pkts++;
            end
        for (int ch = 0; ch < NUM_CH; ch++) expq[ch] = srcq[ch];
        done_at = -1;
        for (int c = 0; c < 1500 && done_at < 0; c++) begin
            st.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            nleft = 0;
            for (int ch = 0; ch < NUM_CH; ch++) nleft += srcq[ch].size();
            if (nleft == 0 && !log_q[log_q.size()-1].ov) done_at = c;
        end
        vecs++; if (done_at < 0) begin errs++; $display("FAIL rand_timeout: got not drained expected drained within 1500 cycles"); end
        st.out_ready = 1'b1;
        tick();
        collect();
        in_pkt = 0; cur_ch = -1;
        foreach (del_q[j]) begin
            vecs++;
            if (del_q[j].ch < 0 || del_q[j].ch >= NUM_CH || expq[del_q[j].ch].size() == 0) begin
                errs++; $display("FAIL rand_channel %0d: got ch=%0d expected a source with pending beats", j, del_q[j].ch);
            end else begin
                if (del_q[j].d !== expq[del_q[j].ch][0].d || del_q[j].sop != expq[del_q[j].ch][0].sop || del_q[j].eop != expq[del_q[j].ch][0].eop) begin
                    errs++; $display("FAIL rand_beat %0d: got ch=%0d d=%h s=%b e=%b expected d=%h s=%b e=%b", j, del_q[j].ch, del_q[j].d,
                                     del_q[j].sop, del_q[j].eop, expq[del_q[j].ch][0].d, expq[del_q[j].ch][0].sop, expq[del_q[j].ch][0].eop);
                end
                void'(expq[del_q[j].ch].pop_front());
            end
            if (in_pkt) begin
                vecs++;
                if (del_q[j].ch != cur_ch) begin errs++; $display("FAIL rand_interleave %0d: got ch=%0d expected ch=%0d", j, del_q[j].ch, cur_ch); end
            end
            if (del_q[j].sop) begin in_pkt = 1; cur_ch = del_q[j].ch; end
            if (del_q[j].eop) in_pkt = 0;
        end
        nleft = 0;
        for (int ch = 0; ch < NUM_CH; ch++) nleft += expq[ch].size();
        vecs++; if (nleft != 0) begin errs++; $display("FAIL rand_lost: got %0d undelivered beats expected 0", nleft); end
        vecs++; if (log_q[log_q.size()-1].pkt !== 16'(total_pkts)) begin errs++; $display("FAIL rand_pkt_count: got %0d expected %0d", log_q[log_q.size()-1].pkt, total_pkts); end
    endtask

    initial begin
        vecs = 0; errs = 0;
        reset = 1'b1; ch_enable = '1;
        st.in_valid = '0; st.in_data = '0; st.in_startofpacket = '0; st.in_endofpacket = '0;
        st.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_orphan();
        test_mask_disable();
        test_saturation_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
